rom_reader: RTL and testbench

Sequential reader for the 512×8 synchronous ROM. On a start pulse it walks the ROM from address 0 upward, honouring the ROM's one-cycle read latency, until it reads the terminator byte 8'hFF or finishes address 511. While walking it accumulates the word count, sum, minimum and maximum, then reports them with a one-cycle completion pulse. It sits between the ROM and the downstream datapath or display logic.

---
 rtl/rom_reader.sv | 164 ++++++++++++++++
 tb/tb_rom_reader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_reader.sv
// Sequential scanner for the 512x8 synchronous ROM: walks from address 0 until
// the terminator byte or the last address, accumulating count, sum, min and max.
module rom_reader #(
  parameter logic [7:0] TERMINADOR = 8'hFF,
  parameter logic [8:0] ULTIMO     = 9'd511
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Iniciar,
  output logic [8:0]  Endereco,
  input  logic [7:0]  Dados,
  output logic        Ocupado,
  output logic        Pronto,
  output logic [9:0]  Contagem,
  output logic [16:0] Soma,
  output logic [7:0]  Minimo,
  output logic [7:0]  Maximo
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ESPERA = 2'd1,
    AVALIA = 2'd2,
    FIM    = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_next_s;

  logic [8:0]  endereco_r;
  logic [8:0]  endereco_next_s;
  logic        ocupado_r;
  logic        ocupado_next_s;
  logic        pronto_r;
  logic        pronto_next_s;
  logic [9:0]  contagem_r;
  logic [9:0]  contagem_next_s;
  logic [16:0] soma_r;
  logic [16:0] soma_next_s;
  logic [7:0]  minimo_r;
  logic [7:0]  minimo_next_s;
  logic [7:0]  maximo_r;
  logic [7:0]  maximo_next_s;

  // State register
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; terminator and last address both end the walk
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (Iniciar) begin
          state_next_s = ESPERA;
        end else begin
          state_next_s = IDLE;
        end
      end
      ESPERA: begin
        state_next_s = AVALIA;
      end
      AVALIA: begin
        if ((Dados == TERMINADOR) || (endereco_r == ULTIMO)) begin
          state_next_s = FIM;
        end else begin
          state_next_s = ESPERA;
        end
      end
      FIM: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Next values of the registered outputs and accumulators
  always_comb begin
    endereco_next_s = endereco_r;
    contagem_next_s = contagem_r;
    soma_next_s     = soma_r;
    minimo_next_s   = minimo_r;
    maximo_next_s   = maximo_r;
    ocupado_next_s  = (state_next_s != IDLE);
    pronto_next_s   = (state_next_s == FIM);
    case (state_r)
      IDLE: begin
        endereco_next_s = 9'd0;
        if (Iniciar) begin
          contagem_next_s = 10'd0;
          soma_next_s     = 17'd0;
          minimo_next_s   = 8'hFF;
          maximo_next_s   = 8'h00;
        end else begin
          contagem_next_s = contagem_r;
        end
      end
      AVALIA: begin
        if (Dados != TERMINADOR) begin
          contagem_next_s = contagem_r + 10'd1;
          soma_next_s     = soma_r + {9'd0, Dados};
          if (Dados < minimo_r) begin
            minimo_next_s = Dados;
          end else begin
            minimo_next_s = minimo_r;
          end
          if (Dados > maximo_r) begin
            maximo_next_s = Dados;
          end else begin
            maximo_next_s = maximo_r;
          end
          // Address stays at the last word so it never wraps to 0
          if (endereco_r != ULTIMO) begin
            endereco_next_s = endereco_r + 9'd1;
          end else begin
            endereco_next_s = endereco_r;
          end
        end else begin
          endereco_next_s = endereco_r;
        end
      end
      default: begin
        endereco_next_s = endereco_r;
      end
    endcase
  end

  // Output and accumulator registers
  always_ff @(posedge CLK) begin
    if (Reset) begin
      endereco_r <= 9'd0;
      ocupado_r  <= 1'b0;
      pronto_r   <= 1'b0;
      contagem_r <= 10'd0;
      soma_r     <= 17'd0;
      minimo_r   <= 8'hFF;
      maximo_r   <= 8'h00;
    end else begin
      endereco_r <= endereco_next_s;
      ocupado_r  <= ocupado_next_s;
      pronto_r   <= pronto_next_s;
      contagem_r <= contagem_next_s;
      soma_r     <= soma_next_s;
      minimo_r   <= minimo_next_s;
      maximo_r   <= maximo_next_s;
    end
  end

  assign Endereco = endereco_r;
  assign Ocupado  = ocupado_r;
  assign Pronto   = pronto_r;
  assign Contagem = contagem_r;
  assign Soma     = soma_r;
  assign Minimo   = minimo_r;
  assign Maximo   = maximo_r;

endmodule

// File: tb/tb_rom_reader.sv
// Scoreboard bench for rom_reader: a behavioural ROM feeds the DUT and each
// scan's expected results and completion edge are queued when it is started.
module tb_rom_reader;

  logic        CLK;
  logic        Reset;
  logic        Iniciar;
  logic [8:0]  Endereco;
  logic [7:0]  Dados;
  logic        Ocupado;
  logic        Pronto;
  logic [9:0]  Contagem;
  logic [16:0] Soma;
  logic [7:0]  Minimo;
  logic [7:0]  Maximo;

  typedef struct {
    int cnt;
    int sum;
    int mn;
    int mx;
    int last;
    int fim_cyc;
  } exp_t;

  logic [7:0] mem [0:511];
  exp_t       q[$];
  int         cyc;
  int         n_chk;
  int         n_pass;
  int         peak;
  logic       pronto_prev;

  rom_reader dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .Iniciar  (Iniciar),
    .Endereco (Endereco),
    .Dados    (Dados),
    .Ocupado  (Ocupado),
    .Pronto   (Pronto),
    .Contagem (Contagem),
    .Soma     (Soma),
    .Minimo   (Minimo),
    .Maximo   (Maximo)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // One-cycle-latency synchronous ROM
  always @(posedge CLK) Dados <= mem[Endereco];

  initial begin
    cyc = 0;
    forever begin
      @(posedge CLK);
      cyc = cyc + 1;
    end
  end

  task automatic check_val(input string tag, input int obs, input int exp_v);
    n_chk = n_chk + 1;
    if (obs === exp_v) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model(input int start_cyc);
    exp_t e;
    e.cnt = 0; e.sum = 0; e.mn = 255; e.mx = 0; e.last = 511;
    for (int i = 0; i < 512; i++) begin
      if (mem[i] == 8'hFF) begin
        e.last = i;
        break;
      end
      e.cnt = e.cnt + 1;
      e.sum = e.sum + int'(mem[i]);
      if (int'(mem[i]) < e.mn) e.mn = int'(mem[i]);
      if (int'(mem[i]) > e.mx) e.mx = int'(mem[i]);
    end
    // edge 0 is the accept edge; the counter has advanced one past it
    e.fim_cyc = start_cyc + 2 * (e.last + 1) + 1;
    return e;
  endfunction

  // Monitor: compares each Pronto pulse against the scoreboard head
  initial begin
    exp_t e;
    pronto_prev = 1'b0;
    peak = 0;
    forever begin
      @(negedge CLK);
      if (Reset) begin
        peak = 0;
      end else if (Ocupado && int'(Endereco) > peak) begin
        peak = int'(Endereco);
      end
      if (Pronto) begin
        if (pronto_prev) begin
          check_val("pronto_width", 2, 1);
        end else if (q.size() == 0) begin
          check_val("pronto_unexpected", 1, 0);
        end else begin
          e = q.pop_front();
          check_val("pronto_cycle", cyc, e.fim_cyc);
          check_val("contagem", int'(Contagem), e.cnt);
          check_val("soma", int'(Soma), e.sum);
          check_val("minimo", int'(Minimo), e.mn);
          check_val("maximo", int'(Maximo), e.mx);
          check_val("endereco_fim", int'(Endereco), e.last);
          check_val("endereco_peak", peak, e.last);
          check_val("ocupado_fim", int'(Ocupado), 1);
        end
        peak = 0;
      end
      pronto_prev = Pronto;
    end
  end

  task automatic check_reset_state(input string tag);
    check_val({tag, "_endereco"}, int'(Endereco), 0);
    check_val({tag, "_ocupado"}, int'(Ocupado), 0);
    check_val({tag, "_pronto"}, int'(Pronto), 0);
    check_val({tag, "_contagem"}, int'(Contagem), 0);
    check_val({tag, "_soma"}, int'(Soma), 0);
    check_val({tag, "_minimo"}, int'(Minimo), 255);
    check_val({tag, "_maximo"}, int'(Maximo), 0);
  endtask

  task automatic load_default();
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    mem[0] = 8'd5; mem[1] = 8'd7; mem[2] = 8'd3; mem[3] = 8'd5;
    mem[4] = 8'd7; mem[5] = 8'd15; mem[6] = 8'hFF;
  endtask

  // Raise Iniciar so the next rising edge is edge 0 of the scan
  task automatic start_pulse(input bit push);
    @(negedge CLK);
    Iniciar = 1'b1;
    if (push) q.push_back(model(cyc));
    @(negedge CLK);
    Iniciar = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 1300 && q.size() != 0; i++) @(negedge CLK);
    if (q.size() != 0) begin
      check_val("scan_timeout", q.size(), 0);
      q.delete();
    end
    repeat (4) @(negedge CLK);
  endtask

  initial begin
    int s0;
    n_chk = 0;
    n_pass = 0;
    Reset = 1'b1;
    Iniciar = 1'b0;
    load_default();
    repeat (3) @(negedge CLK);
    check_reset_state("reset");
    Reset = 1'b0;
    repeat (2) @(negedge CLK);

    start_pulse(1'b1);
    wait_done();

    mem[0] = 8'hFF;
    start_pulse(1'b1);
    wait_done();

    for (int i = 0; i < 512; i++) mem[i] = 8'hFE;
    start_pulse(1'b1);
    wait_done();

    // Extra start requests at edges 3 and 7 must be ignored
    load_default();
    start_pulse(1'b1);
    repeat (2) @(negedge CLK);
    Iniciar = 1'b1;
    @(negedge CLK);
    Iniciar = 1'b0;
    repeat (3) @(negedge CLK);
    Iniciar = 1'b1;
    @(negedge CLK);
    Iniciar = 1'b0;
    wait_done();

    // Iniciar held high: second scan accepted at edge 16
    @(negedge CLK);
    Iniciar = 1'b1;
    s0 = cyc;
    q.push_back(model(s0));
    q.push_back(model(s0 + 16));
    repeat (17) @(posedge CLK);
    @(negedge CLK);
    Iniciar = 1'b0;
    wait_done();

    // Reset sampled at edge 5 aborts the scan without a Pronto pulse
    start_pulse(1'b0);
    repeat (4) @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    check_reset_state("midreset");
    Reset = 1'b0;
    repeat (30) @(negedge CLK);

    start_pulse(1'b1);
    wait_done();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
